// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS controller:
// state codes, opcode/funct constants, ALU codes and the control bundle.
package mips_mc_pkg;

    localparam int unsigned OP_W     = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned STATE_W  = 4;
    localparam int unsigned ALUOP_W  = 2;
    localparam int unsigned ALUCTL_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [ALUCTL_W-1:0] ALUCTL_AND = 3'b000;
    localparam logic [ALUCTL_W-1:0] ALUCTL_OR  = 3'b001;
    localparam logic [ALUCTL_W-1:0] ALUCTL_ADD = 3'b010;
    localparam logic [ALUCTL_W-1:0] ALUCTL_SUB = 3'b110;
    localparam logic [ALUCTL_W-1:0] ALUCTL_SLT = 3'b111;

    // Raw per-state control decode, before reset gating and PCEn merge.
    typedef struct packed {
        logic               pc_write;
        logic               branch;
        logic               iord;
        logic               mem_write;
        logic               ir_write;
        logic               reg_dst;
        logic               mem_to_reg;
        logic               reg_write;
        logic               alu_src_a;
        logic [1:0]         alu_src_b;
        logic [1:0]         pc_src;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    function automatic logic op_supported(input logic [OP_W-1:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_mc_control_if.sv
// Controller <-> datapath bundle: instruction fields and flags in,
// state code and control strobes out.
interface mips_mc_control_if;
    import mips_mc_pkg::*;

    logic [OP_W-1:0]     Op;
    logic [FUNCT_W-1:0]  Funct;
    logic                zero;
    logic                mem_ready;
    logic [STATE_W-1:0]  p_state;
    logic                PCEn;
    logic                IorD;
    logic                MemWrite;
    logic                IRWrite;
    logic                RegDst;
    logic                MemtoReg;
    logic                RegWrite;
    logic                ALUSrcA;
    logic [1:0]          ALUSrcB;
    logic [1:0]          PCSrc;
    logic [ALUCTL_W-1:0] ALUControl;
    logic                illegal;

    modport master (
        input  Op, Funct, zero, mem_ready,
        output p_state, PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, PCSrc, ALUControl, illegal
    );

    modport slave (
        output Op, Funct, zero, mem_ready,
        input  p_state, PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, PCSrc, ALUControl, illegal
    );

endinterface

// File: rtl/mips_alu_dec.sv
// ALU decoder: maps ALUOp and Funct to an ALUControl code; flags an
// unrecognised Funct only when the Funct field is actually consulted.
module mips_alu_dec
    import mips_mc_pkg::*;
(
    input  logic [ALUOP_W-1:0]  ALUOp,
    input  logic [FUNCT_W-1:0]  Funct,
    output logic [ALUCTL_W-1:0] ALUControl,
    output logic                bad_funct
);

    always_comb begin
        ALUControl = ALUCTL_ADD;
        bad_funct  = 1'b0;
        case (ALUOp)
            ALUOP_SUB: ALUControl = ALUCTL_SUB;
            ALUOP_FUNCT: begin
                case (Funct)
                    FN_ADD:  ALUControl = ALUCTL_ADD;
                    FN_SUB:  ALUControl = ALUCTL_SUB;
                    FN_AND:  ALUControl = ALUCTL_AND;
                    FN_OR:   ALUControl = ALUCTL_OR;
                    FN_SLT:  ALUControl = ALUCTL_SLT;
                    default: bad_funct  = 1'b1;
                endcase
            end
            default: ALUControl = ALUCTL_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main controller: state register, next-state logic and
// Moore control decode, with write strobes gated off while reset is low.
module mips_mc_control
    import mips_mc_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    mips_mc_control_if.master bus
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl_c;
    logic   illegal_c;
    logic   bad_funct;

    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next state; unused codes 12-15 fall to FETCH through the default.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (bus.Op == OP_LW)      state_d = S_MEMREAD;
                else if (bus.Op == OP_SW) state_d = S_MEMWRITE;
                else                      state_d = S_FETCH;
            end
            S_MEMREAD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_d = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEXEC: state_d = S_ADDIWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Moore decode; FETCH strobes track mem_ready so a stalled fetch writes nothing.
    always_comb begin
        ctrl_c    = '0;
        illegal_c = 1'b0;
        case (state_q)
            S_FETCH: begin
                ctrl_c.alu_src_b = 2'b01;
                ctrl_c.ir_write  = bus.mem_ready;
                ctrl_c.pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                ctrl_c.alu_src_b = 2'b11;
                illegal_c        = !op_supported(bus.Op);
            end
            S_MEMADR: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = 2'b10;
            end
            S_MEMREAD: ctrl_c.iord = 1'b1;
            S_MEMWB: begin
                ctrl_c.mem_to_reg = 1'b1;
                ctrl_c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl_c.iord      = 1'b1;
                ctrl_c.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_op    = ALUOP_FUNCT;
                illegal_c        = bad_funct;
            end
            S_ALUWB: begin
                ctrl_c.reg_dst   = 1'b1;
                ctrl_c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_op    = ALUOP_SUB;
                ctrl_c.pc_src    = 2'b01;
                ctrl_c.branch    = 1'b1;
            end
            S_ADDIEXEC: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = 2'b10;
            end
            S_ADDIWB: ctrl_c.reg_write = 1'b1;
            S_JUMP: begin
                ctrl_c.pc_src   = 2'b10;
                ctrl_c.pc_write = 1'b1;
            end
            default: ctrl_c = '0;
        endcase
    end

    mips_alu_dec u_alu_dec (
        .ALUOp      (ctrl_c.alu_op),
        .Funct      (bus.Funct),
        .ALUControl (bus.ALUControl),
        .bad_funct  (bad_funct)
    );

    assign bus.p_state  = state_q;
    assign bus.PCEn     = reset & (ctrl_c.pc_write | (ctrl_c.branch & bus.zero));
    assign bus.IRWrite  = reset & ctrl_c.ir_write;
    assign bus.RegWrite = reset & ctrl_c.reg_write;
    assign bus.MemWrite = reset & ctrl_c.mem_write;
    assign bus.illegal  = reset & illegal_c;
    assign bus.IorD     = ctrl_c.iord;
    assign bus.RegDst   = ctrl_c.reg_dst;
    assign bus.MemtoReg = ctrl_c.mem_to_reg;
    assign bus.ALUSrcA  = ctrl_c.alu_src_a;
    assign bus.ALUSrcB  = ctrl_c.alu_src_b;
    assign bus.PCSrc    = ctrl_c.pc_src;

endmodule

// File: doc/mips_mc_control.md
MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

Interface
- Parameters: none.
- REQ-001 clk  input  1  system clock; all state updates on rising edge.
- REQ-002 reset  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- REQ-003 Op  input  6  opcode field, Instr[31:26], from the datapath instruction register.
- REQ-004 Funct  input  6  function field, Instr[5:0].
- REQ-005 zero  input  1  ALU zero flag from the datapath.
- REQ-006 mem_ready  input  1  memory handshake; 1 = current memory access completes this cycle.
- REQ-007 p_state  output  4  current FSM state code.
- REQ-008 Control outputs:
  - PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, each output 1;
  - ALUSrcB output 2; PCSrc output 2; ALUControl output 3.
- REQ-009 illegal  output  1  one-cycle pulse on an unsupported Op or Funct.

Function
- REQ-010 State codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11. Codes 12-15 SHALL go to FETCH next cycle.
- REQ-011 Transitions:
  - FETCH->DECODE when mem_ready=1; otherwise hold FETCH.
  - DECODE by Op: lw 100011 / sw 101011 -> MEMADR; R-type 000000 -> EXECUTE; beq 000100 -> BRANCH; addi 001000 -> ADDIEXEC; j 000010 -> JUMP; any other Op -> FETCH with illegal=1.
  - MEMADR: ->MEMREAD for lw, ->MEMWRITE for sw.
  - MEMREAD->MEMWB when mem_ready=1; otherwise hold.
  - MEMWRITE->FETCH when mem_ready=1; otherwise hold.
  - EXECUTE->ALUWB; ADDIEXEC->ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH.
- REQ-012 Outputs are Moore decodes of p_state. Unlisted signals are 0.
  - FETCH: ALUSrcB=01, IRWrite=mem_ready, PCWrite=mem_ready.
  - DECODE: ALUSrcB=11.
  - MEMADR: ALUSrcA=1, ALUSrcB=10.
  - MEMREAD: IorD=1.
  - MEMWB: MemtoReg=1, RegWrite=1.
  - MEMWRITE: IorD=1, MemWrite=1 for every cycle in the state.
  - EXECUTE: ALUSrcA=1, ALUOp=10.
  - ALUWB: RegDst=1, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1.
  - ADDIEXEC: ALUSrcA=1, ALUSrcB=10.
  - ADDIWB: RegWrite=1.
  - JUMP: PCSrc=10, PCWrite=1.
- REQ-013 PCEn SHALL equal PCWrite OR (Branch AND zero).
- REQ-014 ALUControl decode:
  - ALUOp 00 -> 010 (add); 01 -> 110 (sub).
  - ALUOp 10, by Funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Any other Funct -> 010, with illegal=1 in EXECUTE; the sequence still completes through ALUWB.
- REQ-015 Latency with mem_ready held at 1: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles. Each wait cycle (mem_ready=0) adds 1 cycle.
- REQ-016 Op and Funct SHALL be sampled only in DECODE, MEMADR and EXECUTE; changes in other states have no effect.
- REQ-017 p_state SHALL never hold a value of 12-15 for more than one cycle.

Reset
- REQ-018 reset=0 at a rising edge SHALL set p_state=FETCH, from any state, including mid-instruction and wait states.
- REQ-019 While reset=0, the following SHALL be forced to 0 combinationally: PCEn, IRWrite, RegWrite, MemWrite and illegal.
- REQ-020 First FETCH after reset release: IRWrite and PCEn follow mem_ready.

Structure
- REQ-021 Package mips_mc_pkg SHALL hold:
  - state enum (4-bit, codes per REQ-010);
  - opcode and funct constants;
  - ALUOp and ALUControl codes.
- REQ-022 ALU decode SHALL be a sub-module, mips_alu_dec (inputs ALUOp, Funct; outputs ALUControl, bad_funct).
- REQ-023 State register plus next-state and output logic SHALL reside in mips_mc_control.

Verification
- REQ-024 lw: Op=100011, mem_ready=1 -> p_state 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
- REQ-025 beq: Op=000100, zero=1 -> p_state 0,1,8; PCEn=1 in state 8 with PCSrc=01, ALUControl=110. With zero=0 -> PCEn=0 in state 8.
- REQ-026 R-type slt: Op=000000, Funct=101010 -> ALUControl=111 in state 6; RegDst=1 and RegWrite=1 in state 7.
- REQ-027 Wait states: sw with mem_ready=0 for 3 cycles in MEMWRITE -> p_state=5 held 4 cycles, MemWrite=1 throughout, then FETCH.
- REQ-028 Illegal Op=111111 -> illegal=1 for one cycle in DECODE, next p_state=0, no write enable asserted.
- REQ-029 Reset mid-instruction: reset=0 in state 3 -> p_state=0 next edge; RegWrite and MemWrite stay 0 while reset=0.
